// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader and its byte serializer.
package reg_dump_reader_pkg;

  // Register file index width (32 architectural registers).
  localparam int IDX_W = 5;

  // Dump sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Number of bytes needed to carry one word of the given width.
  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  // Width of a counter that indexes bytes 0..nbytes-1 (at least one bit).
  function automatic int cnt_w(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/reg_byte_serializer.sv
// Loads a word and presents it one byte at a time, least significant byte
// first. The caller owns the valid/ready handshake and pulses shift on
// every accepted byte; last_byte flags the final byte of the word.
module reg_byte_serializer
  import reg_dump_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             shift,
  output logic [7:0]       data,
  output logic             last_byte
);

  localparam int BYTES = bytes_of(WIDTH);
  localparam int CW    = cnt_w(BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;

  // Capture a fresh word on load, otherwise drop the accepted byte on shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shreg_r <= word;
      cnt_r   <= '0;
    end else if (shift) begin
      shreg_r <= shreg_r >> 32'd8;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign data      = shreg_r[7:0];
  assign last_byte = (cnt_r == LAST_CNT);

endmodule

// File: rtl/reg_dump_reader.sv
// Debug-side register file dumper: walks the debug read port over an index
// range (wrapping 31->0), snapshots each register in its SELECT cycle and
// streams the value out LSB-first on a valid/ready byte interface.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       first_sel,
  input  logic [4:0]       last_sel,
  output logic [4:0]       Debug_Source_select,
  input  logic [WIDTH-1:0] Debug_out,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic [4:0]       idx_out,
  output logic             busy,
  output logic             done
);

  localparam int BYTES = bytes_of(WIDTH);

  state_t           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W-1:0] end_r, end_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic             busy_r, valid_r, done_r, final_reg_r;
  logic             load_s, shift_s, accept_s, ser_last_s;

  // Next-state, index bookkeeping and serializer control.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    end_s    = end_r;
    sel_s    = sel_r;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    accept_s = valid_r && byte_ready;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s   = first_sel;
          end_s   = last_sel;
          sel_s   = first_sel;
          state_s = ST_SELECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        // Debug_out is combinational from sel_r; snapshot it now.
        load_s  = 1'b1;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (accept_s) begin
          shift_s = 1'b1;
          if (ser_last_s) begin
            if (idx_r == end_r) begin
              state_s = ST_DONE;
            end else begin
              idx_s   = idx_r + 5'd1;
              sel_s   = idx_r + 5'd1;
              state_s = ST_SELECT;
            end
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, index and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      end_r       <= '0;
      sel_r       <= '0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      final_reg_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      end_r       <= end_s;
      sel_r       <= sel_s;
      busy_r      <= (state_s == ST_SELECT) || (state_s == ST_SEND);
      valid_r     <= (state_s == ST_SEND);
      done_r      <= (state_s == ST_DONE);
      final_reg_r <= (idx_s == end_s);
    end
  end

  reg_byte_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load_s),
    .word      (Debug_out),
    .shift     (shift_s),
    .data      (byte_data),
    .last_byte (ser_last_s)
  );

  assign Debug_Source_select = sel_r;
  assign idx_out             = idx_r;
  assign busy                = busy_r;
  assign byte_valid          = valid_r;
  assign done                = done_r;
  assign byte_last           = valid_r && ser_last_s && final_reg_r;

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug-side reader for the processor register file.
- On request it sweeps the register file's debug read port across a selected index range and captures each register's value.
- It streams each captured value out as bytes over a valid/ready byte interface, which feeds the board UART/debug link.
- It sits beside the register file and drives its debug select input, so it does not disturb either architectural read port.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- BYTES, WIDTH/8, bytes emitted per register; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  dump request; sampled only in IDLE.
- first_sel  input  5  first register index of the dump; sampled with start.
- last_sel  input  5  last register index of the dump; sampled with start.
- Debug_Source_select  output  5  debug read index driven to the register file.
- Debug_out  input  WIDTH  combinational debug read data from the register file.
- byte_data  output  8  current output byte.
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  sink accepts the byte when byte_valid && byte_ready.
- byte_last  output  1  marks the final byte of the whole dump.
- idx_out  output  5  index of the register currently being sent.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0 immediately: Debug_Source_select, byte_data, byte_valid, byte_last, idx_out, busy, done.
  - Any dump in progress is abandoned; no partial byte is held.
  - After reset deasserts, operation resumes from IDLE.
- FSM states: IDLE, SELECT, SEND, DONE.
- IDLE:
  - busy=0, byte_valid=0.
  - If start=1 at an edge: latch first_sel into idx, latch last_sel into end_idx, clear the byte counter, go to SELECT.
- SELECT (exactly one cycle):
  - busy=1, Debug_Source_select=idx, idx_out=idx.
  - At the end of the cycle, Debug_out is captured into the WIDTH-bit shift register. Go to SEND.
- SEND:
  - byte_valid=1; byte_data = shift register bits [7:0], least significant byte first.
  - On byte_valid && byte_ready: shift right by 8 and increment the byte counter.
  - After byte BYTES-1 is accepted: if idx==end_idx go to DONE; otherwise idx=(idx+1) mod 32 and go to SELECT.
  - While byte_ready=0, byte_data, byte_valid and byte_last hold stable; byte_valid never drops without acceptance.
- DONE (one cycle): done=1, busy=0, byte_valid=0, then IDLE.
- byte_last=1 only on byte BYTES-1 of the register where idx==end_idx.
- Snapshot semantics: each register's value is frozen at its SELECT cycle. Writes to that register during its SEND do not change the bytes already captured.
- Latency and throughput:
  - start seen at edge T → busy=1 in cycle T+1 → first byte_valid in cycle T+2.
  - With byte_ready held at 1, each register costs 1+BYTES cycles.
  - N registers take N*(1+BYTES) cycles, then 1 cycle in DONE.
- Range boundaries:
  - first_sel==last_sel: exactly one register is dumped.
  - first_sel>last_sel: the range wraps 31→0; count = (last-first) mod 32 + 1.
  - first_sel=0, last_sel=31: full dump, 32*BYTES bytes.
- start while busy is ignored. first_sel and last_sel changes after start are ignored.
- Debug_Source_select holds its last value outside SELECT; the value is don't-care to the register file.

Decomposition:
- Shared package contents:
  - FSM state encoding (IDLE, SELECT, SEND, DONE).
  - Register index width constant (5).
  - BYTES derivation.
- One natural sub-module, reg_byte_serializer:
  - Loads a WIDTH-bit word and emits bytes LSB-first on valid/ready.
  - Reports last_byte.
  - Is reusable by the future memory-dump reader.

Test Plan:
- Reset then idle: registers preloaded x1=0x11223344; no start → byte_valid=0, busy=0, done=0 for 20 cycles.
- Single register: first=last=1, x1=0x11223344, byte_ready=1 → bytes 0x44,0x33,0x22,0x11 on consecutive cycles starting T+2; byte_last on 0x11; done pulse one cycle later.
- Backpressure: same dump with byte_ready toggling 1,0,0,1 → each byte held stable while ready=0; exactly 4 accepted bytes, no duplicates or drops.
- Wrap range: first=30, last=1, xN=N*0x01010101 → registers 30,31,0,1 in order (x0 = 0x00000000); 16 bytes; idx_out sequence 30,31,0,1.
- Snapshot and busy start: during x5 SEND, write x5=0xDEADBEEF and pulse start → old x5 bytes sent; start ignored; only one done pulse.
- Reset mid-dump: assert reset during byte 2 of register 3 → byte_valid=0 and busy=0 immediately; after release, a new start with first=last=3 dumps x3 from byte 0.
